plru_state_array: RTL and testbench
===================================

Name: plru_state_array

Overview:
- Per-set storage and update engine for the tree-PLRU replacement bits used by the dcache.
- Holds WAYS-1 tree bits per set.
- Applies hit/fill "touch" updates that steer the tree away from the accessed way.
- Supplies the registered bit-vector that the downstream combinational victim-select tree consumes in the following pipeline stage.

Parameters:
- WAYS, 8, associativity; power of two, >=2
- SETS, 16, number of sets; power of two
- IDX_W, $clog2(SETS), set index width
- WAY_W, $clog2(WAYS), way index width
- BITS_W, WAYS-1, tree bits per set

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_valid_i  in  1  lookup request this cycle
- rd_set_i  in  IDX_W  set to read
- touch_valid_i  in  1  access (hit or fill) to record this cycle
- touch_set_i  in  IDX_W  set accessed
- touch_way_i  in  WAY_W  way accessed
- flush_i  in  1  clear all sets to reset state
- plru_valid_o  out  1  plru_bits_o valid (one cycle after rd_valid_i)
- plru_bits_o  out  BITS_W  tree bits of the read set; node n selects child 2n+2 when bit n=1, child 2n+1 when 0

Behaviour:
- Reset:
  - Asynchronous, active-low, fixed: one clock, rst_n asserted low clears state asynchronously.
  - All SETS entries go to 0, plru_valid_o to 0, plru_bits_o to 0 (victim = way 0).
  - Reset mid-operation discards any pending lookup or touch.
- Tree indexing:
  - Nodes 0..BITS_W-1 are internal.
  - Way w is leaf BITS_W+w.
  - Parent of node n is (n-1)>>1.
- Touch update, on the rising edge when touch_valid_i=1:
  - Walk from leaf BITS_W+touch_way_i to the root.
  - At each parent p: if the child is odd (left), bit p <= 1; if even (right), bit p <= 0.
  - Exactly WAY_W bits change; all others keep their stored value.
  - Only entry touch_set_i is written.
- Lookup:
  - rd_valid_i sampled at edge k gives plru_valid_o=1 and plru_bits_o = entry[rd_set_i] after edge k.
  - Latency is 1 cycle, with one lookup per cycle.
  - When rd_valid_i=0, plru_valid_o <= 0 and plru_bits_o holds its last value.
- Read/touch same set, same edge (without bypass): plru_bits_o shows the pre-update contents.
- Touch to a different set than the read: no interaction.
- Back-to-back touches to the same set: each builds on the previous stored value, with no lost update.
- Flush:
  - flush_i=1 at an edge clears every entry to 0 in that single cycle.
  - Flush wins over a simultaneous touch; the touch is dropped.
  - A simultaneous read returns 0.
  - plru_valid_o follows rd_valid_i normally.
- Out-of-range indices cannot occur, since both widths are exact powers of two.
- Storage is a flop array (SETS x BITS_W), not SRAM; reset clears it asynchronously.

Optional Feature:
- Macro: PLRU_BYPASS_EN.
- Defined: when rd_valid_i and touch_valid_i target the same set at the same edge, plru_bits_o returns the post-update value, i.e. the forwarded new bits. Flush still forces 0.
- Undefined: plru_bits_o returns the pre-update stored value, as in Behaviour.

Test Plan:
- Reset then read set 3 (WAYS=8) -> plru_valid_o=1 next cycle, plru_bits_o=7'h00 (victim way 0).
- Touch set 3 way 0, then read set 3 -> plru_bits_o=7'h0B (bits 0,1,3 set; downstream victim = way 4).
- Touch set 3 way 0, next cycle touch set 3 way 4, then read set 3 -> plru_bits_o=7'h2E (downstream victim = way 2); other sets still 7'h00.
- Read and touch of set 5 way 0 on the same edge, from reset -> without PLRU_BYPASS_EN plru_bits_o=7'h00; with it, 7'h0B.
- Populate sets 1 and 2 with touches, then pulse flush_i together with a touch of set 1 way 3 -> reads of sets 1 and 2 return 7'h00.
- Assert rst_n low asynchronously mid-cycle while rd_valid_i=1 -> plru_valid_o and plru_bits_o drop to 0 immediately; all sets read 7'h00 after release.

Source files
------------

// File: rtl/plru_state_array_if.sv
// rtl/plru_state_array_if.sv - lookup/touch/flush bus for the tree-PLRU state array
interface plru_state_array_if #(
    parameter int IDX_W  = 4,
    parameter int WAY_W  = 3,
    parameter int BITS_W = 7
);
    logic              rd_valid_i;
    logic [IDX_W-1:0]  rd_set_i;
    logic              touch_valid_i;
    logic [IDX_W-1:0]  touch_set_i;
    logic [WAY_W-1:0]  touch_way_i;
    logic              flush_i;
    logic              plru_valid_o;
    logic [BITS_W-1:0] plru_bits_o;

    modport master (
        output rd_valid_i, rd_set_i, touch_valid_i, touch_set_i, touch_way_i, flush_i,
        input  plru_valid_o, plru_bits_o
    );

    modport slave (
        input  rd_valid_i, rd_set_i, touch_valid_i, touch_set_i, touch_way_i, flush_i,
        output plru_valid_o, plru_bits_o
    );
endinterface

// File: rtl/plru_state_array.sv
// rtl/plru_state_array.sv - per-set tree-PLRU bit storage and touch update; optional PLRU_BYPASS_EN forwards same-set touches to reads
module plru_state_array #(
    parameter int WAYS   = 8,
    parameter int SETS   = 16,
    parameter int IDX_W  = $clog2(SETS),
    parameter int WAY_W  = $clog2(WAYS),
    parameter int BITS_W = WAYS - 1
) (
    input logic clk,
    input logic rst_n,
    plru_state_array_if.slave bus
);

    logic [BITS_W-1:0] mem [SETS];
    logic [BITS_W-1:0] touched_bits;
    logic [BITS_W-1:0] rd_bits;

    // Walk from the accessed leaf to the root, pointing every ancestor at the sibling subtree.
    function automatic logic [BITS_W-1:0] touch_update(
        input logic [BITS_W-1:0] old_bits,
        input logic [WAY_W-1:0]  way
    );
        logic [BITS_W-1:0] r;
        logic [WAY_W:0]    node;
        logic [WAY_W:0]    node_m1;
        logic [WAY_W-1:0]  parent;
        r    = old_bits;
        node = {1'b0, way} + (WAY_W+1)'(BITS_W);
        for (int l = 0; l < WAY_W; l++) begin
            node_m1   = node - (WAY_W+1)'(1);
            parent    = node_m1[WAY_W:1];
            r[parent] = node[0];
            node      = {1'b0, parent};
        end
        return r;
    endfunction

    // New contents for the set being touched, derived from its currently stored bits.
    always_comb begin
        touched_bits = touch_update(mem[bus.touch_set_i], bus.touch_way_i);
    end

    // Lookup data source: flush reads as zero; same-set touch is forwarded only when bypass is built in.
    always_comb begin
        rd_bits = mem[bus.rd_set_i];
`ifdef PLRU_BYPASS_EN
        if (bus.touch_valid_i && (bus.touch_set_i == bus.rd_set_i)) begin
            rd_bits = touched_bits;
        end
`endif
        if (bus.flush_i) begin
            rd_bits = '0;
        end
    end

    // State array: flush clears everything and drops any concurrent touch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                mem[s] <= '0;
            end
        end else if (bus.flush_i) begin
            for (int s = 0; s < SETS; s++) begin
                mem[s] <= '0;
            end
        end else if (bus.touch_valid_i) begin
            mem[bus.touch_set_i] <= touched_bits;
        end
    end

    // Registered lookup result; bits hold their last value when no lookup is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.plru_valid_o <= 1'b0;
            bus.plru_bits_o  <= '0;
        end else begin
            bus.plru_valid_o <= bus.rd_valid_i;
            if (bus.rd_valid_i) begin
                bus.plru_bits_o <= rd_bits;
            end
        end
    end

endmodule

// File: tb/tb_plru_state_array.sv
// tb/tb_plru_state_array.sv - directed table-driven bench for plru_state_array
module tb_plru_state_array;

    localparam int WAYS   = 8;
    localparam int SETS   = 16;
    localparam int IDX_W  = 4;
    localparam int WAY_W  = 3;
    localparam int BITS_W = 7;

`ifdef PLRU_BYPASS_EN
    localparam logic [6:0] SAME_EDGE_BITS = 7'h0B;
`else
    localparam logic [6:0] SAME_EDGE_BITS = 7'h00;
`endif

    typedef struct {
        logic       rv;
        logic [3:0] rs;
        logic       tv;
        logic [3:0] ts;
        logic [2:0] tw;
        logic       fl;
        logic       ev;
        logic [6:0] eb;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    vec_t vecs [$];

    plru_state_array_if #(.IDX_W(IDX_W), .WAY_W(WAY_W), .BITS_W(BITS_W)) bus ();

    plru_state_array #(.WAYS(WAYS), .SETS(SETS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rv, input logic [3:0] rs, input logic tv, input logic [3:0] ts,
                       input logic [2:0] tw, input logic fl, input logic ev, input logic [6:0] eb);
        vec_t v;
        v.rv = rv; v.rs = rs; v.tv = tv; v.ts = ts; v.tw = tw; v.fl = fl; v.ev = ev; v.eb = eb;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rv, input logic [3:0] rs, input logic tv, input logic [3:0] ts,
                         input logic [2:0] tw, input logic fl);
        bus.rd_valid_i    = rv;
        bus.rd_set_i      = rs;
        bus.touch_valid_i = tv;
        bus.touch_set_i   = ts;
        bus.touch_way_i   = tw;
        bus.flush_i       = fl;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);

        //   rv rs  tv ts tw fl   ev  eb
        add(1, 3,  0, 0, 0, 0,   1, 7'h00);   // read after reset
        add(0, 0,  1, 3, 0, 0,   0, 7'h00);   // touch set3 way0, bits hold
        add(1, 3,  0, 0, 0, 0,   1, 7'h0B);
        add(1, 4,  0, 0, 0, 0,   1, 7'h00);   // untouched set
        add(0, 0,  1, 6, 0, 0,   0, 7'h00);   // back-to-back touches set6
        add(0, 0,  1, 6, 4, 0,   0, 7'h00);
        add(1, 6,  0, 0, 0, 0,   1, 7'h2E);
        add(0, 0,  0, 0, 0, 0,   0, 7'h2E);   // idle: valid drops, bits hold
        add(1, 5,  1, 5, 0, 0,   1, SAME_EDGE_BITS);
        add(1, 5,  0, 0, 0, 0,   1, 7'h0B);
        add(1, 7,  1, 3, 7, 0,   1, 7'h00);   // touch other set, no interaction
        add(1, 3,  0, 0, 0, 0,   1, 7'h0A);
        add(0, 0,  1, 1, 2, 0,   0, 7'h0A);
        add(0, 0,  1, 2, 5, 0,   0, 7'h0A);
        add(1, 1,  0, 0, 0, 0,   1, 7'h11);
        add(1, 2,  0, 0, 0, 0,   1, 7'h04);
        add(1, 1,  1, 1, 3, 1,   1, 7'h00);   // flush beats touch, read returns 0
        add(1, 1,  0, 0, 0, 0,   1, 7'h00);
        add(1, 2,  0, 0, 0, 0,   1, 7'h00);
        add(1, 6,  0, 0, 0, 0,   1, 7'h00);

        // reset state
        #12;
        check("reset_valid", {6'b0, bus.plru_valid_o}, 7'h00);
        check("reset_bits", bus.plru_bits_o, 7'h00);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rv, vecs[i].rs, vecs[i].tv, vecs[i].ts, vecs[i].tw, vecs[i].fl);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), {6'b0, bus.plru_valid_o}, {6'b0, vecs[i].ev});
            check($sformatf("vec%0d_bits", i), bus.plru_bits_o, vecs[i].eb);
        end

        // asynchronous reset mid-cycle with a lookup outstanding
        drive(0, 0, 1, 9, 0, 0);
        @(posedge clk);
        #1;
        drive(1, 9, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("pre_rst_valid", {6'b0, bus.plru_valid_o}, 7'h01);
        check("pre_rst_bits", bus.plru_bits_o, 7'h0B);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {6'b0, bus.plru_valid_o}, 7'h00);
        check("async_rst_bits", bus.plru_bits_o, 7'h00);
        #3;
        rst_n = 1'b1;
        for (int s = 0; s < SETS; s++) begin
            drive(1, s[3:0], 0, 0, 0, 0);
            @(posedge clk);
            #1;
            check($sformatf("post_rst_set%0d", s), bus.plru_bits_o, 7'h00);
        end
        check("post_rst_valid", {6'b0, bus.plru_valid_o}, 7'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
